// File: rtl/uart_cmd_deframer_pkg.sv
// Shared definitions for the UART command deframer.
//   - Command opcodes recognised in the byte stream.
//   - Deframer state encoding (3 bits).
//   - Saturating 8-bit increment used by the drop counter.
package uart_cmd_deframer_pkg;

    localparam logic [7:0] CMD_LOAD   = 8'h80;
    localparam logic [7:0] CMD_STATUS = 8'h40;
    localparam logic [7:0] CMD_READY  = 8'h20;
    localparam logic [7:0] CMD_CLEAR  = 8'h10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GET_HI = 3'd1,
        ST_GET_LO = 3'd2,
        ST_GET_CS = 3'd3,
        ST_PUSH   = 3'd4
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer for the command deframer.
//   clk     : clock
//   rst     : synchronous active-low reset
//   clr     : clear counter to 0 (wins over en)
//   en      : count one per cycle
//   expired : counter has reached TIMEOUT-1
module uart_gap_timer #(
    parameter int TIMEOUT = 100000,
    parameter int TO_W    = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] cnt;

    assign expired = (cnt == TO_W'(TIMEOUT - 1));

    // Holds at the terminal value so a stalled 'en' can never wrap around.
    always_ff @(posedge clk) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + TO_W'(1);
    end

endmodule

// File: rtl/uart_cmd_deframer.sv
// UART command deframer. Decodes the received byte stream into commands:
//   LOAD   (0x80, DH, DL[, CS]) -> one 16-bit FIFO write of {DH,DL}
//   STATUS (0x40) / READY (0x20) -> set sticky flags, CLEAR (0x10) clears both
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   rx_strobe/rx_byte   one-cycle byte-valid strobe and data from the uart
//   recv_error          uart framing error, qualified by rx_strobe
//   fifo_full           downstream FIFO full
//   fifo_wr_en/fifo_din FIFO write port (din = hold register)
//   status_flag         sticky STATUS flag
//   ready_flag          sticky READY flag
//   frame_err           one-cycle pulse on any abort / dropped byte
//   drop_cnt            saturating count of drops
//   busy                state != IDLE
module uart_cmd_deframer
    import uart_cmd_deframer_pkg::*;
#(
    parameter int TIMEOUT  = 100000,
    parameter int TO_W     = 17,
    parameter int USE_CSUM = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_strobe,
    input  logic [7:0]  rx_byte,
    input  logic        recv_error,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [15:0] fifo_din,
    output logic        status_flag,
    output logic        ready_flag,
    output logic        frame_err,
    output logic [7:0]  drop_cnt,
    output logic        busy
);

    state_t      state, next_state;
    logic [15:0] hold;
    logic [7:0]  csum, csum_next;
    logic        err, ld_hi, ld_lo, set_st, set_rd, clr_fl;
    logic        in_frame, to_expired;

    assign in_frame   = (state == ST_GET_HI) || (state == ST_GET_LO) || (state == ST_GET_CS);
    assign fifo_wr_en = (state == ST_PUSH) && !fifo_full;
    assign fifo_din   = hold;
    assign busy       = (state != ST_IDLE);

    // Cleared by every strobe and whenever outside a frame, so entry into
    // GET_HI always starts from zero.
    uart_gap_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (rx_strobe || !in_frame),
        .en      (in_frame),
        .expired (to_expired)
    );

    always_comb begin
        next_state = state;
        csum_next  = csum;
        err        = 1'b0;
        ld_hi      = 1'b0;
        ld_lo      = 1'b0;
        set_st     = 1'b0;
        set_rd     = 1'b0;
        clr_fl     = 1'b0;
        case (state)
            ST_IDLE: begin
                // A byte flagged with a framing error is silently ignored here.
                if (rx_strobe && !recv_error) begin
                    case (rx_byte)
                        CMD_LOAD: begin
                            next_state = ST_GET_HI;
                            csum_next  = CMD_LOAD;
                        end
                        CMD_STATUS: set_st = 1'b1;
                        CMD_READY:  set_rd = 1'b1;
                        CMD_CLEAR:  clr_fl = 1'b1;
                        default:    err    = 1'b1;
                    endcase
                end
            end
            ST_GET_HI: begin
                if (rx_strobe) begin
                    if (recv_error) begin
                        err        = 1'b1;
                        next_state = ST_IDLE;
                    end else begin
                        ld_hi      = 1'b1;
                        csum_next  = csum ^ rx_byte;
                        next_state = ST_GET_LO;
                    end
                end else if (to_expired) begin
                    err        = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            ST_GET_LO: begin
                if (rx_strobe) begin
                    if (recv_error) begin
                        err        = 1'b1;
                        next_state = ST_IDLE;
                    end else begin
                        ld_lo      = 1'b1;
                        csum_next  = csum ^ rx_byte;
                        next_state = (USE_CSUM != 0) ? ST_GET_CS : ST_PUSH;
                    end
                end else if (to_expired) begin
                    err        = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            ST_GET_CS: begin
                if (rx_strobe) begin
                    if (recv_error || (rx_byte != csum)) begin
                        err        = 1'b1;
                        next_state = ST_IDLE;
                    end else begin
                        next_state = ST_PUSH;
                    end
                end else if (to_expired) begin
                    err        = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            ST_PUSH: begin
                // No byte buffer while a word is pending: anything arriving is lost.
                if (rx_strobe)
                    err = 1'b1;
                if (!fifo_full)
                    next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            hold        <= '0;
            csum        <= '0;
            status_flag <= 1'b0;
            ready_flag  <= 1'b0;
            frame_err   <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            state     <= next_state;
            csum      <= csum_next;
            frame_err <= err;
            if (ld_hi)
                hold[15:8] <= rx_byte;
            if (ld_lo)
                hold[7:0] <= rx_byte;
            if (err)
                drop_cnt <= sat_inc8(drop_cnt);
            if (clr_fl) begin
                status_flag <= 1'b0;
                ready_flag  <= 1'b0;
            end else begin
                if (set_st)
                    status_flag <= 1'b1;
                if (set_rd)
                    ready_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_deframer.sv
// Self-checking bench for uart_cmd_deframer: table-driven byte vectors plus
// hand-written sequences for FIFO backpressure, gap timeout, mid-frame reset
// and drop counter saturation.
module tb_uart_cmd_deframer;

    localparam int TIMEOUT = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_strobe = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        recv_error = 1'b0;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_en;
    logic [15:0] fifo_din;
    logic        status_flag, ready_flag, frame_err, busy;
    logic [7:0]  drop_cnt;

    int n_vec = 0;
    int n_err = 0;
    int wr_cnt = 0;
    logic [15:0] last_din = '0;

    uart_cmd_deframer #(.TIMEOUT(TIMEOUT), .TO_W(6), .USE_CSUM(1)) dut (
        .clk(clk), .rst(rst), .rx_strobe(rx_strobe), .rx_byte(rx_byte),
        .recv_error(recv_error), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_din(fifo_din), .status_flag(status_flag), .ready_flag(ready_flag),
        .frame_err(frame_err), .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_wr_en) begin
            wr_cnt   <= wr_cnt + 1;
            last_din <= fifo_din;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [7:0]  b;
        logic        rerr;
        logic        e_err;
        logic        e_busy;
        logic        e_wr;
        logic [15:0] e_din;
        logic        e_st;
        logic        e_rd;
        logic [7:0]  e_drop;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [7:0] b, logic rerr, logic e_err, logic e_busy,
                                logic e_wr, logic [15:0] e_din, logic e_st, logic e_rd,
                                logic [7:0] e_drop);
        vec_t v;
        v.b = b; v.rerr = rerr; v.e_err = e_err; v.e_busy = e_busy; v.e_wr = e_wr;
        v.e_din = e_din; v.e_st = e_st; v.e_rd = e_rd; v.e_drop = e_drop;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Byte is consumed at the next edge; outputs are sampled 1 time unit later.
    task automatic send(input logic [7:0] b, input logic re);
        rx_byte = b; recv_error = re; rx_strobe = 1'b1;
        @(posedge clk); #1;
        rx_strobe = 1'b0; recv_error = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        int w0, k;
        bit seen;

        // Table: b, rerr, err, busy, wr, din, st, rd, drop
        tbl.push_back(mk(8'h80,0, 0,1,0,16'h0000, 0,0,8'd0));
        tbl.push_back(mk(8'h12,0, 0,1,0,16'h0000, 0,0,8'd0));
        tbl.push_back(mk(8'h34,0, 0,1,0,16'h0000, 0,0,8'd0));
        tbl.push_back(mk(8'hA6,0, 0,1,1,16'h1234, 0,0,8'd0));
        tbl.push_back(mk(8'h80,0, 0,1,0,16'h0000, 0,0,8'd0));
        tbl.push_back(mk(8'h12,0, 0,1,0,16'h0000, 0,0,8'd0));
        tbl.push_back(mk(8'h34,0, 0,1,0,16'h0000, 0,0,8'd0));
        tbl.push_back(mk(8'h00,0, 1,0,0,16'h0000, 0,0,8'd1));
        tbl.push_back(mk(8'h40,0, 0,0,0,16'h0000, 1,0,8'd1));
        tbl.push_back(mk(8'h20,0, 0,0,0,16'h0000, 1,1,8'd1));
        tbl.push_back(mk(8'h10,0, 0,0,0,16'h0000, 0,0,8'd1));
        tbl.push_back(mk(8'h55,0, 1,0,0,16'h0000, 0,0,8'd2));
        tbl.push_back(mk(8'h55,1, 0,0,0,16'h0000, 0,0,8'd2));
        tbl.push_back(mk(8'h80,0, 0,1,0,16'h0000, 0,0,8'd2));
        tbl.push_back(mk(8'h40,0, 0,1,0,16'h0000, 0,0,8'd2));
        tbl.push_back(mk(8'h20,0, 0,1,0,16'h0000, 0,0,8'd2));
        tbl.push_back(mk(8'hE0,0, 0,1,1,16'h4020, 0,0,8'd2));
        tbl.push_back(mk(8'h80,0, 0,1,0,16'h0000, 0,0,8'd2));
        tbl.push_back(mk(8'h12,1, 1,0,0,16'h0000, 0,0,8'd3));
        tbl.push_back(mk(8'h40,0, 0,0,0,16'h0000, 1,0,8'd3));

        // Reset state
        idle(2);
        chk("rst_busy", busy, 0);
        chk("rst_wr", fifo_wr_en, 0);
        chk("rst_din", fifo_din, 16'h0000);
        chk("rst_err", frame_err, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_flags", {status_flag, ready_flag}, 0);
        rst = 1'b1;
        idle(1);

        foreach (tbl[i]) begin
            send(tbl[i].b, tbl[i].rerr);
            chk($sformatf("v%0d_err", i), frame_err, tbl[i].e_err);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("v%0d_wr", i), fifo_wr_en, tbl[i].e_wr);
            chk($sformatf("v%0d_flags", i), {status_flag, ready_flag}, {tbl[i].e_st, tbl[i].e_rd});
            chk($sformatf("v%0d_drop", i), drop_cnt, tbl[i].e_drop);
            if (tbl[i].e_wr)
                chk($sformatf("v%0d_din", i), fifo_din, tbl[i].e_din);
            idle(1);
        end
        chk("tbl_wr_count", wr_cnt, 2);
        chk("tbl_idle", busy, 0);

        // FIFO backpressure with a byte arriving during the wait
        do_reset();
        w0 = wr_cnt;
        fifo_full = 1'b1;
        send(8'h80, 0); send(8'hAB, 0); send(8'hCD, 0); send(8'hE6, 0);
        chk("full_busy", busy, 1);
        chk("full_no_wr", fifo_wr_en, 0);
        idle(5);
        send(8'h40, 0);
        chk("push_drop_err", frame_err, 1);
        chk("push_drop_cnt", drop_cnt, 1);
        chk("push_drop_noflag", status_flag, 0);
        idle(12);
        chk("full_no_write", wr_cnt, w0);
        chk("full_still_busy", busy, 1);
        fifo_full = 1'b0;
        #1;
        chk("unfull_wr", fifo_wr_en, 1);
        chk("unfull_din", fifo_din, 16'hABCD);
        idle(1);
        chk("unfull_one_write", wr_cnt, w0 + 1);
        chk("unfull_last_din", last_din, 16'hABCD);
        chk("unfull_idle", busy, 0);

        // Gap timeout
        do_reset();
        send(8'h80, 0); send(8'h12, 0);
        k = 0; seen = 0;
        while (!seen && k < 3 * TIMEOUT) begin
            idle(1);
            k++;
            if (frame_err) seen = 1;
        end
        chk("to_seen", seen, 1);
        chk("to_cycles", k, TIMEOUT);
        chk("to_idle", busy, 0);
        chk("to_drop", drop_cnt, 1);
        idle(1);
        chk("to_pulse_1cyc", frame_err, 0);
        w0 = wr_cnt;
        send(8'h80, 0); send(8'h12, 0); send(8'h34, 0); send(8'hA6, 0);
        idle(1);
        chk("to_next_write", wr_cnt, w0 + 1);
        chk("to_next_din", last_din, 16'h1234);

        // Reset mid-frame
        do_reset();
        w0 = wr_cnt;
        send(8'h40, 0);
        send(8'h80, 0); send(8'h12, 0); send(8'h34, 0);
        rst = 1'b0;
        idle(1);
        chk("mrst_outs", {busy, fifo_wr_en, frame_err, status_flag, ready_flag}, 0);
        chk("mrst_drop", drop_cnt, 0);
        chk("mrst_din", fifo_din, 16'h0000);
        rst = 1'b1;
        send(8'hA6, 0);
        chk("mrst_a6_err", frame_err, 1);
        chk("mrst_a6_drop", drop_cnt, 1);
        idle(3);
        chk("mrst_no_write", wr_cnt, w0);
        chk("mrst_idle", busy, 0);

        // Drop counter saturation
        do_reset();
        for (int j = 0; j < 260; j++) send(8'h55, 0);
        chk("drop_sat", drop_cnt, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
